// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
// Holds the register offsets, status bit positions, buffer depth and the
// receiver FSM state/register struct. The struct is the FSM's own state
// register, so the current state and bit position are visible from one place.
package uart_pkg;

  // Register offsets relative to the Wishbone base address.
  localparam logic [31:0] RX_DATA_OFS = 32'h0;
  localparam logic [31:0] RX_STAT_OFS = 32'h4;

  // Status register bit positions.
  localparam int RXAV_BIT = 0;
  localparam int OVR_BIT  = 1;
  localparam int FERR_BIT = 2;

  // Depth of the optional receive FIFO.
  localparam int FIFO_DEPTH = 4;

  // Bit-timing counter width; covers CLKS_PER_BIT up to 65535.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Complete receiver FSM register. An all-zero value is the reset state.
  typedef struct packed {
    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
  } rx_fsm_t;

  function automatic logic [31:0] stat_word(input logic rxav,
                                            input logic ovr,
                                            input logic ferr);
    logic [31:0] w;
    w           = '0;
    w[RXAV_BIT] = rxav;
    w[OVR_BIT]  = ovr;
    w[FERR_BIT] = ferr;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// 4-entry x 8-bit synchronous FIFO for received bytes.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata       write request and data; ignored when full unless a pop
//                     happens in the same cycle
//   pop               read request; ignored when empty
//   rdata             oldest entry (combinational, valid when !empty)
//   full, empty       occupancy flags
// A push and pop in the same cycle on a full FIFO both take effect: the slot
// being vacated by the pop receives the new byte.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'b0, do_push} - {2'b0, do_pop};
    end
  end

endmodule

// File: rtl/uart_rx_wb.sv
// UART receiver (8N1) with a Wishbone register window.
// Parameters: WB_ADDR (base byte address), CLK_FREQ (Hz), BAUD (bit/s).
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_wb_adr/dat/we/stb      Wishbone request
//   o_wb_dat, o_wb_ack       registered read data, single-cycle acknowledge
//   i_uart_rx                asynchronous serial line, idle high
// Registers:
//   WB_ADDR+0  read: {24'b0, oldest byte} and pop (0 when empty); writes ignored
//   WB_ADDR+4  read: {29'b0, FERR, OVR, RXAV}; write 1 to bit1/bit2 clears OVR/FERR
// Handshake: a strobe to a mapped address is accepted when o_wb_ack is low;
// the ack and read data appear in the following cycle for exactly one cycle,
// so a strobe held high is accepted every other cycle. Unmapped addresses are
// never acknowledged.
// Build option: define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise
// a single holding register with a valid bit is used.
module uart_rx_wb
  import uart_pkg::*;
#(
  parameter logic [31:0] WB_ADDR  = 32'h40000200,
  parameter int          CLK_FREQ = 10000000,
  parameter int          BAUD     = 115200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  input  logic        i_uart_rx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  // ---------------------------------------------------------------- sync
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_uart_rx};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------- FSM
  rx_fsm_t fsm_q;
  rx_fsm_t fsm_d;
  logic    push;
  logic    ferr_set;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q <= '0;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (fsm_q.state)
      ST_IDLE: begin
        if (!rx_s) begin
          fsm_d.state = ST_START;
          fsm_d.cnt   = '0;
        end
      end
      ST_START: begin
        // Re-check the line mid start bit; a high line means a glitch.
        if (fsm_q.cnt == HALF_LAST) begin
          fsm_d.cnt     = '0;
          fsm_d.bit_idx = '0;
          fsm_d.state   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          fsm_d.cnt = fsm_q.cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (fsm_q.cnt == BIT_LAST) begin
          fsm_d.cnt     = '0;
          fsm_d.shreg   = {rx_s, fsm_q.shreg[7:1]};
          fsm_d.bit_idx = fsm_q.bit_idx + 3'd1;
          if (fsm_q.bit_idx == 3'd7) begin
            fsm_d.state = ST_STOP;
          end
        end else begin
          fsm_d.cnt = fsm_q.cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (fsm_q.cnt == BIT_LAST) begin
          fsm_d.cnt   = '0;
          fsm_d.state = ST_IDLE;
          push        = rx_s;
          ferr_set    = ~rx_s;
        end else begin
          fsm_d.cnt = fsm_q.cnt + 1'b1;
        end
      end
      default: fsm_d = '0;
    endcase
  end

  // ---------------------------------------------------------------- buffer
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] head;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .wdata (fsm_q.shreg),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
`else
  logic [7:0] hold_q;
  logic       valid_q;

  // Push with a simultaneous pop replaces the held byte and stays valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push && (!valid_q || pop)) begin
      hold_q  <= fsm_q.shreg;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign full  = valid_q;
  assign empty = ~valid_q;
  assign head  = hold_q;
`endif

  // ---------------------------------------------------------------- bus
  logic        hit_data;
  logic        hit_stat;
  logic        accept;
  logic        clr_ovr;
  logic        clr_ferr;
  logic        ovr_set;
  logic        ovr_q;
  logic        ferr_q;
  logic [31:0] rd_word;
  logic        unused_wb_dat;

  assign hit_data = (i_wb_adr == (WB_ADDR + RX_DATA_OFS));
  assign hit_stat = (i_wb_adr == (WB_ADDR + RX_STAT_OFS));
  // o_wb_ack high blocks acceptance, which spaces acks one cycle apart.
  assign accept   = i_wb_stb & ~o_wb_ack & (hit_data | hit_stat);
  assign pop      = accept & hit_data & ~i_wb_we & ~empty;
  assign clr_ovr  = accept & hit_stat & i_wb_we & i_wb_dat[OVR_BIT];
  assign clr_ferr = accept & hit_stat & i_wb_we & i_wb_dat[FERR_BIT];
  // Overrun only when no pop frees a slot in the same cycle.
  assign ovr_set  = push & full & ~pop;

  assign unused_wb_dat = ^{i_wb_dat[31:3], i_wb_dat[0]};

  always_comb begin
    rd_word = '0;
    if (hit_data) begin
      if (!empty) begin
        rd_word = {24'b0, head};
      end
    end else begin
      rd_word = stat_word(~empty, ovr_q, ferr_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      o_wb_ack <= accept;
      if (accept) begin
        o_wb_dat <= rd_word;
      end
      // A set in the same cycle as its clear wins.
      ovr_q  <= ovr_set  | (ovr_q  & ~clr_ovr);
      ferr_q <= ferr_set | (ferr_q & ~clr_ferr);
    end
  end

endmodule

// File: tb/tb_uart_rx_wb.sv
// Testbench for uart_rx_wb: serial frames and Wishbone accesses checked
// against a queue-based model of the receive buffer and status flags.
module tb_uart_rx_wb;
  import uart_pkg::*;

  localparam logic [31:0] BASE     = 32'h40000200;
  localparam logic [31:0] DATA_A   = BASE;
  localparam logic [31:0] STAT_A   = BASE + 32'h4;
  localparam logic [31:0] BAD_A    = BASE + 32'h8;
  localparam int          BIT_CLKS = 10000000 / 115200;
  // Posedge, counted from the negedge the start bit begins on, at which the
  // stop bit is sampled: two sync flops, idle detect, half bit, 8 data bits, stop.
  localparam int          PUSH_EDGE = 3 + BIT_CLKS / 2 + 9 * BIT_CLKS;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic        i_clk     = 1'b0;
  logic        i_rst     = 1'b1;
  logic [31:0] i_wb_adr  = '0;
  logic [31:0] i_wb_dat  = '0;
  logic        i_wb_we   = 1'b0;
  logic        i_wb_stb  = 1'b0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        i_uart_rx = 1'b1;

  always #5 i_clk = ~i_clk;

  uart_rx_wb dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wb_adr  (i_wb_adr),
    .i_wb_dat  (i_wb_dat),
    .i_wb_we   (i_wb_we),
    .i_wb_stb  (i_wb_stb),
    .o_wb_dat  (o_wb_dat),
    .o_wb_ack  (o_wb_ack),
    .i_uart_rx (i_uart_rx)
  );

  // ---------------------------------------------------------------- model
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  bit         m_ovr     = 1'b0;
  bit         m_ferr    = 1'b0;

  function automatic logic [31:0] model_stat();
    return {29'b0, m_ferr, m_ovr, (exp_q.size() != 0)};
  endfunction

  function automatic logic [31:0] model_pop();
    if (exp_q.size() == 0) return 32'h0;
    return {24'b0, exp_q.pop_front()};
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      repeat (BIT_CLKS) @(negedge i_clk);
    end
    i_uart_rx = stop_ok;
    repeat (BIT_CLKS) @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (16) @(negedge i_clk);
  endtask

  task automatic wb_access(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                           output logic [31:0] rdat, output bit acked);
    @(negedge i_clk);
    i_wb_adr = adr;
    i_wb_we  = we;
    i_wb_dat = wdat;
    i_wb_stb = 1'b1;
    acked    = 1'b0;
    rdat     = '0;
    for (int i = 0; i < 16 && !acked; i++) begin
      @(posedge i_clk);
      #1;
      if (o_wb_ack) begin
        acked = 1'b1;
        rdat  = o_wb_dat;
      end
    end
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat, output bit acked);
    wb_access(adr, 1'b0, 32'h0, rdat, acked);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat, output bit acked);
    logic [31:0] dummy;
    wb_access(adr, 1'b1, wdat, dummy, acked);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    i_rst     = 1'b1;
    i_uart_rx = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    total_cnt++;
    if (dut.sync_q !== 2'b11) $display("FAIL reset_sync: got %b expected 11", dut.sync_q);
    else pass_cnt++;
    total_cnt++;
    if (dut.fsm_q.state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.fsm_q.state, ST_IDLE);
    else pass_cnt++;
    total_cnt++;
    if ({o_wb_ack, o_wb_dat} !== 33'h0) $display("FAIL reset_bus: got ack=%0d dat=%h expected ack=0 dat=0", o_wb_ack, o_wb_dat);
    else pass_cnt++;
    @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL reset_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_frame_a5();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL a5_stat_before: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_read(DATA_A, d, a);
    e = model_pop();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL a5_data: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL a5_stat_after: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_framing_error();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    send_frame(8'h5A, 1'b0);
    model_frame(8'h5A, 1'b0);
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL ferr_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_read(DATA_A, d, a);
    e = model_pop();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL ferr_no_byte: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_write(STAT_A, 32'h4, a);
    m_ferr = 1'b0;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL ferr_cleared: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    total_cnt++;
    if (dut.fsm_q.state !== ST_START) $display("FAIL glitch_start: got %0d expected %0d", dut.fsm_q.state, ST_START);
    else pass_cnt++;
    repeat (15) @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (80) @(negedge i_clk);
    total_cnt++;
    if (dut.fsm_q.state !== ST_IDLE) $display("FAIL glitch_idle: got %0d expected %0d", dut.fsm_q.state, ST_IDLE);
    else pass_cnt++;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL glitch_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1);
      model_frame(8'(b), 1'b1);
    end
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL ovr_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      wb_read(DATA_A, d, a);
      e = model_pop();
      total_cnt++;
      if ({a, d} !== {1'b1, e}) $display("FAIL ovr_data%0d: got ack=%0d dat=%h expected ack=1 dat=%h", i, a, d, e);
      else pass_cnt++;
    end
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL ovr_stat_drained: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_write(STAT_A, 32'h2, a);
    m_ovr = 1'b0;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL ovr_cleared: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    logic [7:0]  b;
    b = 8'($urandom_range(0, 255));
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      i_uart_rx = b[i];
      repeat (BIT_CLKS) @(negedge i_clk);
    end
    i_uart_rx = b[4];
    repeat (BIT_CLKS / 2) @(negedge i_clk);
    i_rst     = 1'b1;
    i_uart_rx = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    repeat (20) @(negedge i_clk);
    total_cnt++;
    if (dut.fsm_q.state !== ST_IDLE) $display("FAIL rst_mid_state: got %0d expected %0d", dut.fsm_q.state, ST_IDLE);
    else pass_cnt++;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL rst_mid_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL rst_mid_stat_3c: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_read(DATA_A, d, a);
    e = model_pop();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL rst_mid_data_3c: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_bus_edges();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    wb_read(BAD_A, d, a);
    total_cnt++;
    if (a !== 1'b0) $display("FAIL bad_addr_ack: got ack=%0d expected ack=0", a);
    else pass_cnt++;
    wb_read(DATA_A, d, a);
    e = model_pop();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL empty_read: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_write(DATA_A, 32'hFFFF_FFFF, a);
    total_cnt++;
    if (a !== 1'b1) $display("FAIL data_write_ack: got ack=%0d expected ack=1", a);
    else pass_cnt++;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL data_write_ignored: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  task automatic test_strobe_held();
    int acks;
    bit prev;
    bit consec;
    acks   = 0;
    prev   = 1'b0;
    consec = 1'b0;
    @(negedge i_clk);
    i_wb_adr = STAT_A;
    i_wb_we  = 1'b0;
    i_wb_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      if (o_wb_ack && prev) consec = 1'b1;
      acks += int'(o_wb_ack);
      prev  = o_wb_ack;
    end
    i_wb_stb = 1'b0;
    @(negedge i_clk);
    total_cnt++;
    if (acks !== 3) $display("FAIL held_ack_count: got %0d expected 3", acks);
    else pass_cnt++;
    total_cnt++;
    if (consec !== 1'b0) $display("FAIL held_ack_consecutive: got %0d expected 0", consec);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    logic [7:0]  b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_frame(b, 1'b1);
    end
    b = 8'($urandom_range(0, 255));
    fork
      send_frame(b, 1'b1);
      begin
        @(negedge i_clk);
        repeat (PUSH_EDGE - 1) @(posedge i_clk);
        wb_read(DATA_A, d, a);
      end
    join
    e = model_pop();
    model_frame(b, 1'b1);
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL pushpop_data: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL pushpop_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      wb_read(DATA_A, d, a);
      e = model_pop();
      total_cnt++;
      if ({a, d} !== {1'b1, e}) $display("FAIL pushpop_drain%0d: got ack=%0d dat=%h expected ack=1 dat=%h", i, a, d, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    bit          a;
    logic [31:0] e;
    logic [7:0]  b;
    bit          ok;
    for (int n = 0; n < 8; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      model_frame(b, ok);
      wb_read(STAT_A, d, a);
      e = model_stat();
      total_cnt++;
      if ({a, d} !== {1'b1, e}) $display("FAIL rand_stat%0d: got ack=%0d dat=%h expected ack=1 dat=%h", n, a, d, e);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) begin
        wb_read(DATA_A, d, a);
        e = model_pop();
        total_cnt++;
        if ({a, d} !== {1'b1, e}) $display("FAIL rand_data%0d: got ack=%0d dat=%h expected ack=1 dat=%h", n, a, d, e);
        else pass_cnt++;
      end
    end
    while (exp_q.size() != 0) begin
      wb_read(DATA_A, d, a);
      e = model_pop();
      total_cnt++;
      if ({a, d} !== {1'b1, e}) $display("FAIL rand_drain: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
      else pass_cnt++;
    end
    wb_write(STAT_A, 32'h6, a);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wb_read(STAT_A, d, a);
    e = model_stat();
    total_cnt++;
    if ({a, d} !== {1'b1, e}) $display("FAIL rand_final_stat: got ack=%0d dat=%h expected ack=1 dat=%h", a, d, e);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_frame_a5();
    test_framing_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_bus_edges();
    test_strobe_held();
    test_push_pop_full();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
